// File: rtl/affine_ctrl_vars_gen.sv
// affine_ctrl_vars_gen: schedule-driven 4-deep affine loop-nest walker feeding one ub port.
// AFFINE_CTRL_LAST_EN adds a 'last' output flagging the final iteration's enable.
module affine_ctrl_vars_gen #(
   parameter int NUM_DIMS = 4,
   parameter int VAR_W    = 16,
   parameter int TIME_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       start,
   input  logic                       stall,
   input  logic [NUM_DIMS*VAR_W-1:0]  extent,
   input  logic [NUM_DIMS*TIME_W-1:0] time_stride,
   input  logic [TIME_W-1:0]          offset,
   output logic                       valid,
   output logic [NUM_DIMS*VAR_W-1:0]  ctrl_vars,
   output logic                       busy,
   output logic                       done,
   output logic                       error
`ifdef AFFINE_CTRL_LAST_EN
   ,
   output logic                       last
`endif
);
   localparam int KW = (NUM_DIMS > 1) ? $clog2(NUM_DIMS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                            state;
   logic [NUM_DIMS-1:0][VAR_W-1:0]    ext, idx, nidx;
   logic [NUM_DIMS-1:0][TIME_W-1:0]   stride, tb, ntb;
   logic [TIME_W-1:0]                 cnt, cnt_nx, base;
   logic [KW-1:0]                     kb;
   logic                              found, any_zero;

   assign ext       = extent;
   assign stride    = time_stride;
   assign ctrl_vars = idx;
   assign busy      = state == RUN;
   assign done      = state == FIN;
   assign cnt_nx    = cnt + TIME_W'(1);
   assign valid     = busy && !stall && (cnt >= tb[NUM_DIMS-1]);
`ifdef AFFINE_CTRL_LAST_EN
   assign last      = valid && !found;
`endif

   // Odometer: kb is the innermost dimension still below its extent
   always_comb begin
      found    = 1'b0;
      kb       = '0;
      any_zero = 1'b0;
      for (int d = 0; d < NUM_DIMS; d++) begin
         if (idx[d] != ext[d] - VAR_W'(1)) begin
            found = 1'b1;
            kb    = KW'(d);
         end
         if (ext[d] == '0) any_zero = 1'b1;
      end
      base = tb[kb] + stride[kb];
      nidx = idx;
      ntb  = tb;
      for (int d = 0; d < NUM_DIMS; d++) begin
         if (d >= int'(kb)) begin
            nidx[d] = (d == int'(kb)) ? idx[d] + VAR_W'(1) : '0;
            ntb[d]  = base;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         tb    <= '0;
         cnt   <= '0;
         error <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         idx   <= '0;
         tb    <= '0;
         cnt   <= '0;
         error <= 1'b0;
      end else if (state != RUN && start) begin
         state <= any_zero ? FIN : RUN;
         idx   <= '0;
         tb    <= {NUM_DIMS{offset}};
         cnt   <= '0;
         error <= 1'b0;
      end else if (state == RUN && !stall) begin
         cnt <= cnt_nx;
         if (valid) begin
            if (!found) begin
               state <= FIN;
            end else begin
               idx <= nidx;
               tb  <= ntb;
               // Late iteration still fires next cycle; only flag it
               if (ntb[NUM_DIMS-1] <= cnt_nx) error <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_affine_ctrl_vars_gen.sv
// tb_affine_ctrl_vars_gen: directed self-checking bench for affine_ctrl_vars_gen.
// Cycle c is the clock period ending at the c-th edge after the start edge.
module tb_affine_ctrl_vars_gen;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         start = 1'b0;
   logic         stall = 1'b0;
   logic [63:0]  extent = '0;
   logic [127:0] time_stride = '0;
   logic [31:0]  offset = '0;
   logic         valid, busy, done, error;
   logic [63:0]  ctrl_vars;
`ifdef AFFINE_CTRL_LAST_EN
   logic         last;
`endif

   int errors = 0;
   int checks = 0;
   int vc[$];
   logic [63:0] vv[$];
   int done_c, err_c, last_c, last_n;
   bit busy_seen;

   affine_ctrl_vars_gen dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .stall(stall),
      .extent(extent), .time_stride(time_stride), .offset(offset),
      .valid(valid), .ctrl_vars(ctrl_vars), .busy(busy), .done(done), .error(error)
`ifdef AFFINE_CTRL_LAST_EN
      , .last(last)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic logic [127:0] pks(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   // Nominal-walk index sequence for extent {1,2,2,3}
   function automatic logic [63:0] nom_vars(input int i);
      return pk(0, (i / 6) % 2, (i / 3) % 2, i % 3);
   endfunction

   // Entered #1 after a posedge; pulses start, then records ncyc cycles
   task automatic run(input int ncyc, input int s_lo, input int s_hi, input int re_start);
      vc.delete();
      vv.delete();
      done_c = -1; err_c = -1; last_c = -1; last_n = 0; busy_seen = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         stall = (c >= s_lo) && (c <= s_hi);
         start = (c == re_start);
         @(negedge clk);
         if (valid) begin
            vc.push_back(c);
            vv.push_back(ctrl_vars);
         end
         if (busy) busy_seen = 1;
         if (done && done_c < 0) done_c = c;
         if (error && err_c < 0) err_c = c;
`ifdef AFFINE_CTRL_LAST_EN
         if (last) begin
            last_n++;
            last_c = c;
         end
`endif
         @(posedge clk);
         #1;
      end
      stall = 1'b0;
      start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 64'(valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_error"}, 64'(error), 64'd0);
      check({tag, "_vars"}, ctrl_vars, 64'd0);
   endtask

   initial begin
      extent      = pk(1, 2, 2, 3);
      time_stride = pks(0, 12, 6, 2);
      offset      = 32'd5;
      repeat (3) @(posedge clk);
      #1 check_idle("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Nominal walk with an ignored start pulse at cycle 15
      run(32, -1, -1, 15);
      check("nom_count", 64'(vc.size()), 64'd12);
      for (int i = 0; i < vc.size() && i < 12; i++) begin
         check($sformatf("nom_cyc%0d", i), 64'(vc[i]), 64'(6 + 2 * i));
         check($sformatf("nom_vars%0d", i), vv[i], nom_vars(i));
      end
      check("nom_done", 64'(done_c), 64'd29);
      check("nom_err", 64'(err_c), 64'hffff_ffff_ffff_ffff);
`ifdef AFFINE_CTRL_LAST_EN
      check("last_count", 64'(last_n), 64'd1);
      check("last_cyc", 64'(last_c), 64'd28);
`endif

      // Stall over cycles 10..12 delays the tail by 3 cycles
      run(34, 10, 12, -1);
      check("stall_count", 64'(vc.size()), 64'd12);
      for (int i = 0; i < vc.size() && i < 12; i++) begin
         check($sformatf("stall_cyc%0d", i), 64'(vc[i]), 64'(i < 2 ? 6 + 2 * i : 9 + 2 * i));
         check($sformatf("stall_vars%0d", i), vv[i], nom_vars(i));
      end
      check("stall_done", 64'(done_c), 64'd32);

      // Empty domain
      extent = pk(1, 2, 0, 3);
      run(5, -1, -1, -1);
      check("empty_count", 64'(vc.size()), 64'd0);
      check("empty_done", 64'(done_c), 64'd1);
      check("empty_busy", 64'(busy_seen), 64'd0);

      // Schedule violation
      extent      = pk(1, 1, 2, 3);
      time_stride = pks(0, 0, 1, 4);
      offset      = 32'd0;
      run(16, -1, -1, -1);
      check("viol_count", 64'(vc.size()), 64'd6);
      check("viol_err", 64'(err_c), 64'd10);
      if (vc.size() >= 6) begin
         check("viol_cyc3", 64'(vc[3]), 64'd10);
         check("viol_vars3", vv[3], pk(0, 0, 1, 0));
         check("viol_cyc5", 64'(vc[5]), 64'd12);
         check("viol_vars5", vv[5], pk(0, 0, 1, 2));
      end
      check("viol_sticky", 64'(error), 64'd1);

      // Flush mid-run, then replay
      extent      = pk(1, 2, 2, 3);
      time_stride = pks(0, 12, 6, 2);
      offset      = 32'd5;
      run(14, -1, -1, -1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check_idle("flush");
      run(32, -1, -1, -1);
      check("flush_rep_count", 64'(vc.size()), 64'd12);
      if (vc.size() > 0) begin
         check("flush_rep_cyc0", 64'(vc[0]), 64'd6);
         check("flush_rep_vars0", vv[0], 64'd0);
      end

      // Asynchronous reset mid-run, then replay
      run(14, -1, -1, -1);
      #2 rst_n = 1'b0;
      #1 check_idle("arst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run(32, -1, -1, -1);
      check("arst_rep_count", 64'(vc.size()), 64'd12);
      if (vc.size() > 0) begin
         check("arst_rep_cyc0", 64'(vc[0]), 64'd6);
         check("arst_rep_vars0", vv[0], 64'd0);
      end
      check("arst_rep_done", 64'(done_c), 64'd29);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/affine_ctrl_vars_gen.md
Name: affine_ctrl_vars_gen

Overview:
- Schedule-driven iteration-domain generator; the producing end of the unified-buffer port protocol.
- Walks a 4-deep affine loop nest.
- Each scheduled cycle it asserts one enable and presents the current loop indices as ctrl_vars.
- The enable drives a ub port's *_wen or *_ren, with ctrl_vars wired straight to the matching *_ctrl_vars input.
- One instance per ub port.
- Index 0 is the root (outermost) dimension; index 3 is the innermost.

Parameters:
- NUM_DIMS, 4, loop-nest depth; must match ub ctrl_vars depth.
- VAR_W, 16, width of each loop index and each extent.
- TIME_W, 32, width of the cycle counter, schedule offset, strides and per-dimension time bases.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear to IDLE; higher priority than every input except rst_n.
- start  in  1  begin a new walk; sampled only in IDLE or DONE.
- stall  in  1  freeze: cycle counter, indices and time bases hold; valid forced 0.
- extent  in  NUM_DIMS x VAR_W  trip count per dimension; held stable while busy.
- time_stride  in  NUM_DIMS x TIME_W  cycles added to the schedule per increment of that dimension.
- offset  in  TIME_W  cycle of the first iteration, relative to RUN entry.
- valid  out  1  enable to the ub port (wen/ren).
- ctrl_vars  out  NUM_DIMS x VAR_W  current loop indices.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- error  out  1  sticky schedule-violation flag.

Behaviour:
- Reset (rst_n low, asynchronous) and flush: state = IDLE; valid, ctrl_vars, busy, done, error, cycle_cnt and all time_base registers clear to 0.
- States:
  - IDLE: start moves to RUN, or to DONE if any extent is 0 (no valid is ever issued).
  - RUN: walks the nest; moves to DONE after the final iteration's valid.
  - DONE: held until start (back to RUN, same rules as IDLE) or flush (to IDLE).
- Start sampled at edge t:
  - cycle_cnt = 0, every index = 0, every time_base = offset, error cleared.
  - RUN begins in cycle t+1.
  - First valid occurs in cycle t+1+offset, assuming no stalls.
- Firing rule: valid = (state==RUN) && !stall && (cycle_cnt >= time_base[NUM_DIMS-1]), decoded combinationally from registers. ctrl_vars are registered and stable during valid.
- Each unstalled RUN cycle, cycle_cnt increments, wrapping at 2^TIME_W; no overflow detection.
- Advance, on the edge ending a valid cycle, odometer style:
  - k = innermost dimension with index < extent-1.
  - index[k] increments; all indices j>k reset to 0.
  - time_base[k] += time_stride[k]; every time_base[j] for j>k is set to the new time_base[k].
  - If no such k exists, this was the last iteration: go to DONE, indices hold their final values.
- Schedule violation: after an advance, if the new time_base[NUM_DIMS-1] <= cycle_cnt (post-increment), error sets and stays set until start/flush. The late iteration still fires on the next unstalled cycle, so no iteration is dropped.
- Stall: freezes all state; no valid.
- start while in RUN: ignored.
- stall and flush together: flush wins.
- Ports of ub receiving valid see exactly prod(extent) enables per walk, indices in lexicographic order.

Optional Feature:
- Macro: AFFINE_CTRL_LAST_EN.
- Defined: extra output port last (1 bit), asserted together with valid on the final iteration of the walk only; reset value 0.
- Undefined: port absent; no other behaviour changes.

Test Plan:
- Nominal walk:
  - Setup: extent={1,2,2,3}, time_stride={0,12,6,2}, offset=5, start at edge 0.
  - Required: 12 valids at cycles 6,8,10,…,28; ctrl_vars sequence {0,0,0,0},{0,0,0,1},{0,0,0,2},{0,0,1,0}…{0,1,1,2}; done=1 from cycle 29; error=0.
- Stall:
  - Stimulus: same config, stall high for cycles 10–12.
  - Required: valid absent at cycle 10; the remaining 10 valids (from cycle 10 onward) land on cycles 13,15,…,31; same index order.
- Empty domain:
  - Stimulus: extent[2]=0, then start.
  - Required: DONE next cycle, zero valids, busy never 1.
- Schedule violation:
  - Stimulus: extent={1,1,2,3}, time_stride={0,0,1,4}, offset=0.
  - Required: error=1 after the third valid; fourth valid ({0,0,1,0}) issued on the next cycle; total valids = 6.
- Flush and reset mid-run:
  - Stimulus: flush mid-RUN; separately, rst_n low mid-RUN.
  - Required: all outputs 0 immediately (reset asynchronously, flush at the next edge); a subsequent start replays the walk from {0,0,0,0}.
- Ignored start and last flag:
  - Stimulus: start pulsed while busy; with AFFINE_CTRL_LAST_EN defined.
  - Required: the busy-time start has no effect on timing; with the macro defined, last=1 only with the 12th valid in the nominal walk.
